// File: rtl/systolic_skew_feeder.sv
// Diagonal skew feeder for the systolic array west edge.
// Takes one matrix row per handshake and delays lane c by c cycles so that
// every PE row sees its operands on the correct wavefront. After the last row
// it keeps shifting zeros in until the final element has left the last lane.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for start, nothing accepted
// FEED  | accepting rows; each accepted row advances the skew pipeline
// DRAIN | shifting zero wavefronts in for M_COL-1 cycles
// DONE  | run complete, feed_done held until next start
module systolic_skew_feeder #(
  parameter int M_ROW  = 9,
  parameter int M_COL  = 9,
  parameter int DATA_W = 32
) (
  input  logic                    M_AXI_ACLK,
  input  logic                    M_AXI_ARESET,
  input  logic                    start,
  input  logic [M_COL*DATA_W-1:0] row_data,
  input  logic                    row_valid,
  output logic                    row_ready,
  output logic [M_COL*DATA_W-1:0] skew_data,
  output logic                    skew_valid,
  output logic                    busy,
  output logic                    feed_done
);

  localparam int RCW = ($clog2(M_ROW + 1) > 1) ? $clog2(M_ROW + 1) : 1;
  localparam int DCW = ($clog2(M_COL) > 1) ? $clog2(M_COL) : 1;

  // Terminal counts: the accept/drain cycle on which the counter holds these
  // values is the last one of its phase.
  localparam logic [RCW-1:0] ROW_LAST   = RCW'(M_ROW - 1);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(M_COL - 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [RCW-1:0] row_cnt;
  logic [DCW-1:0] drain_cnt;
  logic           accept;
  logic           advance;
  logic           clear;

  // Handshake and pipeline-control strobes derived from the current state.
  always_comb begin
    row_ready = 1'b0;
    busy      = 1'b0;
    feed_done = 1'b0;
    case (state)
      S_FEED: begin
        row_ready = 1'b1;
        busy      = 1'b1;
      end
      S_DRAIN: busy      = 1'b1;
      S_DONE:  feed_done = 1'b1;
      default: ;
    endcase
  end

  assign accept  = row_valid && row_ready;
  assign advance = accept || (state == S_DRAIN);
  // start is honoured only between runs; it wipes any residue of a prior run.
  assign clear   = start && ((state == S_IDLE) || (state == S_DONE));

  // State register.
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_FEED;
      end
      S_FEED: begin
        if (accept && (row_cnt == ROW_LAST)) begin
          // A single lane has nothing to drain behind the last row.
          state_nxt = (M_COL == 1) ? S_DONE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_cnt == DRAIN_LAST) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (start) state_nxt = S_FEED;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Row and drain counters; both restart from zero on every run.
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      row_cnt   <= '0;
      drain_cnt <= '0;
    end else if (clear) begin
      row_cnt   <= '0;
      drain_cnt <= '0;
    end else begin
      if (accept)             row_cnt   <= row_cnt + 1'b1;
      if (state == S_DRAIN)   drain_cnt <= drain_cnt + 1'b1;
    end
  end

  // Output strobe marks the cycle after each pipeline advance.
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      skew_valid <= 1'b0;
    end else if (clear) begin
      skew_valid <= 1'b0;
    end else begin
      skew_valid <= advance;
    end
  end

  for (genvar c = 0; c < M_COL; c++) begin : g_lane
    logic [DATA_W-1:0] lane_in;
    logic [DATA_W-1:0] lane_q;

    // Zeros are shifted in while draining so trailing wavefronts are padded.
    assign lane_in = (state == S_FEED) ? row_data[c*DATA_W +: DATA_W] : '0;

    if (c == 0) begin : g_direct
      // Lane 0 has no skew: only the output register.
      always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
          lane_q <= '0;
        end else if (clear) begin
          lane_q <= '0;
        end else if (advance) begin
          lane_q <= lane_in;
        end
      end
    end else begin : g_delayed
      logic [DATA_W-1:0] stg [c];

      // c delay stages then the output register, all shifting together.
      always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
          for (int s = 0; s < c; s++) stg[s] <= '0;
          lane_q <= '0;
        end else if (clear) begin
          for (int s = 0; s < c; s++) stg[s] <= '0;
          lane_q <= '0;
        end else if (advance) begin
          stg[0] <= lane_in;
          for (int s = 1; s < c; s++) stg[s] <= stg[s-1];
          lane_q <= stg[c-1];
        end
      end
    end

    assign skew_data[c*DATA_W +: DATA_W] = lane_q;
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Self-checking bench for systolic_skew_feeder: a 3x3 instance checked
// through an expected-wavefront queue, plus a 2-row single-lane instance.
module tb_systolic_skew_feeder;

  localparam int MR = 3;
  localparam int MC = 3;
  localparam int DW = 32;
  localparam int NW = MR + MC - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic                 start = 1'b0;
  logic [MC*DW-1:0]     row_data = '0;
  logic                 row_valid = 1'b0;
  logic                 row_ready;
  logic [MC*DW-1:0]     skew_data;
  logic                 skew_valid;
  logic                 busy;
  logic                 feed_done;

  logic                 start2 = 1'b0;
  logic [DW-1:0]        row_data2 = '0;
  logic                 row_valid2 = 1'b0;
  logic                 row_ready2;
  logic [DW-1:0]        skew_data2;
  logic                 skew_valid2;
  logic                 busy2;
  logic                 feed_done2;

  int checks = 0;
  int errors = 0;
  int wave_cnt = 0;
  int rr_cnt = 0;
  logic [MC*DW-1:0] exp_q [$];

  always #5 clk = ~clk;

  systolic_skew_feeder #(.M_ROW(MR), .M_COL(MC), .DATA_W(DW)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst), .start(start),
    .row_data(row_data), .row_valid(row_valid), .row_ready(row_ready),
    .skew_data(skew_data), .skew_valid(skew_valid), .busy(busy),
    .feed_done(feed_done)
  );

  systolic_skew_feeder #(.M_ROW(2), .M_COL(1), .DATA_W(DW)) dut2 (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst), .start(start2),
    .row_data(row_data2), .row_valid(row_valid2), .row_ready(row_ready2),
    .skew_data(skew_data2), .skew_valid(skew_valid2), .busy(busy2),
    .feed_done(feed_done2)
  );

  function automatic logic [MC*DW-1:0] pack_row(int mult, int r);
    logic [MC*DW-1:0] v;
    v = '0;
    for (int c = 0; c < MC; c++) v[c*DW +: DW] = DW'(mult * r + c);
    return v;
  endfunction

  // Wavefront k (1-based): lane c carries row k-1-c when that row exists.
  function automatic logic [MC*DW-1:0] exp_wave(int mult, int k);
    logic [MC*DW-1:0] v;
    int idx;
    v = '0;
    for (int c = 0; c < MC; c++) begin
      idx = k - 1 - c;
      if (idx >= 0 && idx < MR) v[c*DW +: DW] = DW'(mult * idx + c);
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every wavefront must match the head of the queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (row_ready) rr_cnt++;
      if (skew_valid) begin
        wave_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_wavefront: got %h, none expected", skew_data);
        end else begin
          logic [MC*DW-1:0] e;
          e = exp_q.pop_front();
          if (skew_data !== e) begin
            errors++;
            $display("FAIL wavefront %0d: got %h, expected %h", wave_cnt, skew_data, e);
          end
        end
      end
    end
  end

  task automatic run_seq(int mult, bit stall, bit ign);
    int n;
    for (int k = 1; k <= NW; k++) exp_q.push_back(exp_wave(mult, k));
    wave_cnt = 0;
    rr_cnt = 0;
    if (ign) begin
      row_data = pack_row(mult, 2);
      row_valid = 1'b1;
      tick();
      tick();
      row_valid = 1'b0;
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (row_ready !== 1'b1 || busy !== 1'b1 || feed_done !== 1'b0) begin
      errors++;
      $display("FAIL feed_entry: ready=%b busy=%b done=%b, expected 1 1 0", row_ready, busy, feed_done);
    end
    for (int r = 0; r < MR; r++) begin
      row_data = pack_row(mult, r);
      row_valid = 1'b1;
      if (ign && r == 1) start = 1'b1;
      tick();
      start = 1'b0;
      row_valid = 1'b0;
      if (stall && r == 1) begin
        for (int s = 0; s < 2; s++) begin
          tick();
          checks++;
          if (skew_valid !== 1'b0 || skew_data !== exp_wave(mult, 2)) begin
            errors++;
            $display("FAIL stall_hold: valid=%b data=%h, expected 0 %h", skew_valid, skew_data, exp_wave(mult, 2));
          end
        end
      end
    end
    if (ign) begin
      row_data = pack_row(mult, 0);
      row_valid = 1'b1;
    end
    n = 0;
    while (feed_done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    row_valid = 1'b0;
    checks++;
    if (n != MC - 1) begin
      errors++;
      $display("FAIL done_latency: got %0d cycles after last accept, expected %0d", n, MC - 1);
    end
    tick();
    checks++;
    if (wave_cnt != NW || exp_q.size() != 0) begin
      errors++;
      $display("FAIL wave_count: got %0d (left %0d), expected %0d", wave_cnt, exp_q.size(), NW);
      exp_q.delete();
    end
    checks++;
    if (rr_cnt != MR + (stall ? 2 : 0)) begin
      errors++;
      $display("FAIL row_ready_cycles: got %0d, expected %0d", rr_cnt, MR + (stall ? 2 : 0));
    end
    checks++;
    if (feed_done !== 1'b1 || busy !== 1'b0 || skew_valid !== 1'b0) begin
      errors++;
      $display("FAIL done_state: done=%b busy=%b valid=%b, expected 1 0 0", feed_done, busy, skew_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    checks++;
    if (skew_data !== '0 || skew_valid !== 1'b0 || row_ready !== 1'b0 ||
        busy !== 1'b0 || feed_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: data=%h v=%b rdy=%b busy=%b done=%b, expected all 0",
               skew_data, skew_valid, row_ready, busy, feed_done);
    end
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if (skew_valid !== 1'b0 || row_ready !== 1'b0 || feed_done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: v=%b rdy=%b done=%b, expected 0 0 0", skew_valid, row_ready, feed_done);
    end
  endtask

  task automatic test_basic();
    run_seq(32'h10, 1'b0, 1'b0);
  endtask

  task automatic test_restart();
    run_seq(32'h100, 1'b0, 1'b0);
  endtask

  task automatic test_stall();
    run_seq(32'h10, 1'b1, 1'b0);
  endtask

  task automatic test_ignored();
    run_seq(32'h20, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_run();
    for (int k = 1; k <= NW; k++) exp_q.push_back(exp_wave(32'h10, k));
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int r = 0; r < MR; r++) begin
      row_data = pack_row(32'h10, r);
      row_valid = 1'b1;
      tick();
    end
    row_valid = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (skew_data !== '0 || skew_valid !== 1'b0 || busy !== 1'b0 ||
        row_ready !== 1'b0 || feed_done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: data=%h v=%b busy=%b rdy=%b done=%b, expected all 0",
               skew_data, skew_valid, busy, row_ready, feed_done);
    end
    checks++;
    if (exp_q.size() != 2) begin
      errors++;
      $display("FAIL pre_reset_waves: %0d left, expected 2", exp_q.size());
    end
    exp_q.delete();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (skew_valid !== 1'b0 || feed_done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_idle: v=%b done=%b busy=%b, expected 0 0 0", skew_valid, feed_done, busy);
      end
    end
  endtask

  task automatic test_degenerate();
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    checks++;
    if (row_ready2 !== 1'b1) begin
      errors++;
      $display("FAIL deg_ready: got %b, expected 1", row_ready2);
    end
    row_data2 = 32'h00;
    row_valid2 = 1'b1;
    tick();
    checks++;
    if (skew_valid2 !== 1'b1 || skew_data2 !== 32'h00 || busy2 !== 1'b1 || feed_done2 !== 1'b0) begin
      errors++;
      $display("FAIL deg_wave1: v=%b d=%h busy=%b done=%b, expected 1 00 1 0", skew_valid2, skew_data2, busy2, feed_done2);
    end
    row_data2 = 32'h10;
    tick();
    row_valid2 = 1'b0;
    checks++;
    if (skew_valid2 !== 1'b1 || skew_data2 !== 32'h10 || busy2 !== 1'b0 || feed_done2 !== 1'b1) begin
      errors++;
      $display("FAIL deg_wave2: v=%b d=%h busy=%b done=%b, expected 1 10 0 1", skew_valid2, skew_data2, busy2, feed_done2);
    end
    tick();
    checks++;
    if (skew_valid2 !== 1'b0 || feed_done2 !== 1'b1 || row_ready2 !== 1'b0) begin
      errors++;
      $display("FAIL deg_no_drain: v=%b done=%b rdy=%b, expected 0 1 0", skew_valid2, feed_done2, row_ready2);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_restart();
    test_stall();
    test_ignored();
    test_reset_mid_run();
    test_degenerate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
